// File: rtl/mx_mov_pkg.sv
// Shared definitions for the MOV transfer sequencer: register codes, FSM states and the index map.
// The exchange states are only reachable when MOV_SWAP_EN is defined.
package mx_mov_pkg;

    localparam int SWAP_STATES = 6;

    localparam logic [3:0] REG_A     = 4'h0;
    localparam logic [3:0] REG_X     = 4'h1;
    localparam logic [3:0] REG_Y     = 4'h2;
    localparam logic [3:0] REG_D     = 4'h3;
    localparam logic [3:0] REG_DAR   = 4'h4;
    localparam logic [3:0] REG_MBR   = 4'h5;
    localparam logic [3:0] REG_INSP  = 4'h6;
    localparam logic [3:0] REG_FLAGS = 4'h7;
    localparam logic [3:0] REG_SA    = 4'h8;
    localparam logic [3:0] REG_SB    = 4'h9;
    localparam logic [3:0] REG_SC    = 4'hA;
    localparam logic [3:0] REG_SD    = 4'hB;
    localparam logic [3:0] REG_R0    = 4'hC;
    localparam logic [3:0] REG_R1    = 4'hD;
    localparam logic [3:0] REG_R2    = 4'hE;
    localparam logic [3:0] REG_R3    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_RD,
        ST_LAT,
        ST_WR,
        ST_RD2,
        ST_LAT2,
        ST_WR2
    } state_e;

    // Returns {src, dst} for a 5-bit MOV index.
    function automatic logic [7:0] mov_map(input logic [4:0] idx);
        logic [7:0] entry;
        case (idx)
            5'd0:    entry = {REG_A,     REG_X};
            5'd1:    entry = {REG_X,     REG_A};
            5'd2:    entry = {REG_A,     REG_Y};
            5'd3:    entry = {REG_Y,     REG_A};
            5'd4:    entry = {REG_A,     REG_D};
            5'd5:    entry = {REG_D,     REG_A};
            5'd6:    entry = {REG_A,     REG_FLAGS};
            5'd7:    entry = {REG_FLAGS, REG_A};
            5'd8:    entry = {REG_X,     REG_Y};
            5'd9:    entry = {REG_Y,     REG_X};
            5'd10:   entry = {REG_X,     REG_D};
            5'd11:   entry = {REG_D,     REG_X};
            5'd12:   entry = {REG_Y,     REG_D};
            5'd13:   entry = {REG_D,     REG_Y};
            5'd14:   entry = {REG_A,     REG_INSP};
            5'd15:   entry = {REG_INSP,  REG_A};
            5'd16:   entry = {REG_SA,    REG_A};
            5'd17:   entry = {REG_SB,    REG_X};
            5'd18:   entry = {REG_SC,    REG_Y};
            5'd19:   entry = {REG_SD,    REG_D};
            5'd20:   entry = {REG_A,     REG_SA};
            5'd21:   entry = {REG_X,     REG_SB};
            5'd22:   entry = {REG_Y,     REG_SC};
            5'd23:   entry = {REG_D,     REG_SD};
            5'd24:   entry = {REG_R0,    REG_DAR};
            5'd25:   entry = {REG_R1,    REG_MBR};
            5'd26:   entry = {REG_R2,    REG_INSP};
            5'd27:   entry = {REG_R3,    REG_FLAGS};
            5'd28:   entry = {REG_DAR,   REG_R0};
            5'd29:   entry = {REG_MBR,   REG_R1};
            5'd30:   entry = {REG_INSP,  REG_R2};
            default: entry = {REG_FLAGS, REG_R3};
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/mov_xfer_map.sv
// Combinational MOV index -> {src, dst} register-code lookup.
module mov_xfer_map
    import mx_mov_pkg::*;
(
    input  logic [4:0] idx,
    output logic [3:0] src,
    output logic [3:0] dst
);

    logic [7:0] entry;

    assign entry = mov_map(idx);
    assign src   = entry[7:4];
    assign dst   = entry[3:0];

endmodule

// File: rtl/mov_xfer_seq.sv
// MOV register-transfer sequencer: handshake, bus arbitration and read-latch-write on the register file.
// Define MOV_SWAP_EN to add the swap port and the register exchange path.
module mov_xfer_seq
    import mx_mov_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       insr_valid,
    input  logic [7:0] insr,
    output logic       insr_ready,
`ifdef MOV_SWAP_EN
    input  logic       swap,
`endif
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       rd_en,
    output logic [3:0] rd_sel,
    input  logic [7:0] rd_data,
    output logic       wr_en,
    output logic [3:0] wr_sel,
    output logic [7:0] wr_data,
    output logic       done,
    output logic       err
);

    state_e     state_q, state_d;
    logic [3:0] src_q, src_d;
    logic [3:0] dst_q, dst_d;
    logic [7:0] tmp_q, tmp_d;
    logic       err_q, err_d;
    logic       rst_hold_q, rst_hold_d;
    logic [3:0] map_src, map_dst;
    logic       is_mov;
    logic       accept;
    logic       swap_path;
`ifdef MOV_SWAP_EN
    logic       swap_q, swap_d;
    logic [7:0] tmp2_q, tmp2_d;
`endif

    mov_xfer_map u_map (
        .idx (insr[4:0]),
        .src (map_src),
        .dst (map_dst)
    );

    assign is_mov = (insr[7:5] == 3'b000);
    assign err    = err_q;

    // rst_hold_q keeps insr_ready low for the first cycle after reset is released.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        tmp_d      = tmp_q;
        err_d      = 1'b0;
        rst_hold_d = 1'b0;
        insr_ready = (state_q == ST_IDLE) && !rst_hold_q;
        accept     = insr_valid && insr_ready;
        bus_req    = 1'b0;
        rd_en      = 1'b0;
        rd_sel     = 4'h0;
        wr_en      = 1'b0;
        wr_sel     = 4'h0;
        wr_data    = 8'h00;
        done       = 1'b0;
`ifdef MOV_SWAP_EN
        swap_d     = swap_q;
        tmp2_d     = tmp2_q;
        swap_path  = swap_q;
`else
        swap_path  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mov) begin
                        src_d   = map_src;
                        dst_d   = map_dst;
`ifdef MOV_SWAP_EN
                        swap_d  = swap;
`endif
                        state_d = ST_ARB;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ARB: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                bus_req = 1'b1;
                rd_en   = 1'b1;
                rd_sel  = src_q;
                state_d = swap_path ? ST_RD2 : ST_LAT;
            end
            ST_LAT: begin
                bus_req = 1'b1;
                tmp_d   = rd_data;
                state_d = ST_WR;
            end
            ST_WR: begin
                bus_req = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = dst_q;
                wr_data = tmp_q;
                done    = !swap_path;
                state_d = swap_path ? ST_WR2 : ST_IDLE;
            end
`ifdef MOV_SWAP_EN
            // The destination read overlaps the cycle that latches the source value.
            ST_RD2: begin
                bus_req = 1'b1;
                rd_en   = 1'b1;
                rd_sel  = dst_q;
                tmp_d   = rd_data;
                state_d = ST_LAT2;
            end
            ST_LAT2: begin
                bus_req = 1'b1;
                tmp2_d  = rd_data;
                state_d = ST_WR;
            end
            ST_WR2: begin
                bus_req = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = src_q;
                wr_data = tmp2_q;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= 4'h0;
            dst_q      <= 4'h0;
            tmp_q      <= 8'h00;
            err_q      <= 1'b0;
            rst_hold_q <= 1'b1;
`ifdef MOV_SWAP_EN
            swap_q     <= 1'b0;
            tmp2_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            tmp_q      <= tmp_d;
            err_q      <= err_d;
            rst_hold_q <= rst_hold_d;
`ifdef MOV_SWAP_EN
            swap_q     <= swap_d;
            tmp2_q     <= tmp2_d;
`endif
        end
    end

endmodule
